// File: rtl/byte_frame_assembler_if.sv
// rtl/byte_frame_assembler_if.sv - byte strobe, payload read and frame hand-off signals
//
// master: upstream byte source / frame consumer (drives trigger_in, data_in, rd_addr, pkt_ack)
// slave : byte_frame_assembler (drives rd_data, pkt_ready, pkt_len, pkt_err, drop_cnt)
interface byte_frame_assembler_if #(
    parameter int MAX_LEN = 16
) ();
    localparam int AW = $clog2(MAX_LEN);

    logic          trigger_in;
    logic [7:0]    data_in;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          pkt_ack;
    logic          pkt_ready;
    logic [AW:0]   pkt_len;
    logic          pkt_err;
    logic [7:0]    drop_cnt;

    modport master (
        output trigger_in, data_in, rd_addr, pkt_ack,
        input  rd_data, pkt_ready, pkt_len, pkt_err, drop_cnt
    );

    modport slave (
        input  trigger_in, data_in, rd_addr, pkt_ack,
        output rd_data, pkt_ready, pkt_len, pkt_err, drop_cnt
    );
endinterface

// File: rtl/byte_frame_assembler.sv
// rtl/byte_frame_assembler.sv - assembles SYNC/LEN/payload/CHK byte frames into a readable buffer
//
// Ports:
//   clk, rst_n      : single rising-edge clock, asynchronous active-low reset
//   bus.trigger_in  : one-cycle strobe qualifying bus.data_in
//   bus.data_in     : incoming byte
//   bus.rd_addr     : payload read index, bus.rd_data returns buffer[rd_addr] one cycle later
//   bus.pkt_ready   : a checked frame is held; bus.pkt_len is its payload length
//   bus.pkt_ack     : consumer releases the held frame
//   bus.pkt_err     : one-cycle pulse on bad length or bad checksum
//   bus.drop_cnt    : bytes discarded while holding, saturating at 8'hFF
module byte_frame_assembler #(
    parameter int MAX_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    byte_frame_assembler_if.slave bus
);
    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = AW + 1;
    localparam logic [7:0] SYNC_BYTE = 8'hAA;
    localparam logic [8:0] MAX_LEN9  = 9'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE,
        GET_LEN,
        GET_PAY,
        GET_CHK,
        HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [7:0]    chk_q, chk_d;
    logic          pkt_err_q, pkt_err_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic [7:0]    rd_data_q;

    logic [7:0]    buf_mem [MAX_LEN];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [LW-1:0] idx_inc;
    logic          len_bad;

    assign idx_inc = idx_q + LW'(1);
    // LEN is compared on 9 bits so that MAX_LEN=256 never wraps.
    assign len_bad = (bus.data_in == 8'h00) || ({1'b0, bus.data_in} > MAX_LEN9);
    assign wr_addr = idx_q[AW-1:0];

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        chk_d      = chk_q;
        pkt_err_d  = 1'b0;
        drop_cnt_d = drop_cnt_q;
        wr_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.trigger_in && bus.data_in == SYNC_BYTE) begin
                    state_d = GET_LEN;
                end
            end
            GET_LEN: begin
                if (bus.trigger_in) begin
                    if (len_bad) begin
                        pkt_err_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        len_d   = LW'({1'b0, bus.data_in});
                        chk_d   = bus.data_in;
                        idx_d   = '0;
                        state_d = GET_PAY;
                    end
                end
            end
            GET_PAY: begin
                if (bus.trigger_in) begin
                    wr_en = 1'b1;
                    chk_d = chk_q ^ bus.data_in;
                    idx_d = idx_inc;
                    if (idx_inc == len_q) begin
                        state_d = GET_CHK;
                    end
                end
            end
            GET_CHK: begin
                if (bus.trigger_in) begin
                    if (bus.data_in == chk_q) begin
                        state_d = HOLD;
                    end else begin
                        pkt_err_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            HOLD: begin
                // A strobe arriving with pkt_ack is still a dropped byte.
                if (bus.trigger_in && drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
                if (bus.pkt_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            chk_q      <= 8'h00;
            pkt_err_q  <= 1'b0;
            drop_cnt_q <= 8'h00;
            rd_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            chk_q      <= chk_d;
            pkt_err_q  <= pkt_err_d;
            drop_cnt_q <= drop_cnt_d;
            rd_data_q  <= buf_mem[bus.rd_addr];
        end
    end

    // Payload storage is deliberately not reset; only GET_PAY writes it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[wr_addr] <= bus.data_in;
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.pkt_ready = (state_q == HOLD);
    assign bus.pkt_len   = len_q;
    assign bus.pkt_err   = pkt_err_q;
    assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_byte_frame_assembler.sv
// tb/tb_byte_frame_assembler.sv - self-checking bench for byte_frame_assembler
module tb_byte_frame_assembler;
    localparam int MAX_LEN = 16;
    localparam int AW = $clog2(MAX_LEN);

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    byte_frame_assembler_if #(.MAX_LEN(MAX_LEN)) bus ();

    byte_frame_assembler #(.MAX_LEN(MAX_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: bytes after a SYNC are gathered into a queue and the
    // whole frame is judged once its length is known.
    logic [7:0] m_frame [$];
    bit         m_in_frame;
    bit         m_hold;
    bit         m_err;
    int         m_len;
    int         m_drop;
    logic [7:0] m_mem [MAX_LEN];
    bit         m_known [MAX_LEN];
    logic [7:0] m_rd;
    bit         m_rd_known;

    initial begin
        for (int i = 0; i < MAX_LEN; i++) m_known[i] = 1'b0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            m_frame.delete();
            m_in_frame = 1'b0;
            m_hold     = 1'b0;
            m_err      = 1'b0;
            m_len      = 0;
            m_drop     = 0;
            m_rd       = 8'h00;
            m_rd_known = 1'b1;
            check("rst_ready", 32'(bus.pkt_ready), 32'd0);
            check("rst_err", 32'(bus.pkt_err), 32'd0);
            check("rst_len", 32'(bus.pkt_len), 32'd0);
            check("rst_drop", 32'(bus.drop_cnt), 32'd0);
            check("rst_rd", 32'(bus.rd_data), 32'd0);
        end else begin
            bit was_hold;
            check("mon_ready", 32'(bus.pkt_ready), 32'(m_hold));
            check("mon_err", 32'(bus.pkt_err), 32'(m_err));
            check("mon_drop", 32'(bus.drop_cnt), 32'(m_drop));
            if (m_hold) check("mon_len", 32'(bus.pkt_len), 32'(m_len));
            if (m_rd_known) check("mon_rd", 32'(bus.rd_data), 32'(m_rd));

            // next-cycle expectations from the inputs the coming edge will see
            m_rd_known = m_known[bus.rd_addr];
            m_rd       = m_mem[bus.rd_addr];
            m_err      = 1'b0;
            was_hold   = m_hold;
            if (bus.trigger_in) begin
                if (m_hold) begin
                    if (m_drop < 255) m_drop++;
                end else if (!m_in_frame) begin
                    if (bus.data_in == 8'hAA) begin
                        m_in_frame = 1'b1;
                        m_frame.delete();
                    end
                end else begin
                    m_frame.push_back(bus.data_in);
                    if (m_frame.size() == 1) begin
                        if (bus.data_in == 8'h00 || int'(bus.data_in) > MAX_LEN) begin
                            m_err      = 1'b1;
                            m_in_frame = 1'b0;
                        end
                    end else if (m_frame.size() <= int'(m_frame[0]) + 1) begin
                        m_mem[m_frame.size() - 2]   = bus.data_in;
                        m_known[m_frame.size() - 2] = 1'b1;
                    end else begin
                        logic [7:0] x;
                        x = 8'h00;
                        for (int i = 0; i < m_frame.size() - 1; i++) x ^= m_frame[i];
                        if (x == bus.data_in) begin
                            m_hold = 1'b1;
                            m_len  = int'(m_frame[0]);
                        end else begin
                            m_err = 1'b1;
                        end
                        m_in_frame = 1'b0;
                    end
                end
            end
            if (was_hold && bus.pkt_ack) m_hold = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.trigger_in = 1'b1;
        bus.data_in    = b;
        tick();
        bus.trigger_in = 1'b0;
    endtask

    task automatic ack();
        bus.pkt_ack = 1'b1;
        tick();
        bus.pkt_ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] pay35 [16];

    initial begin
        checks = 0;
        fails  = 0;
        rst_n          = 1'b0;
        bus.trigger_in = 1'b0;
        bus.data_in    = 8'h00;
        bus.rd_addr    = '0;
        bus.pkt_ack    = 1'b0;
        pay35 = '{8'hAA, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                  8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hAA};
        tick();
        tick();
        check("reset_drop", 32'(bus.drop_cnt), 32'h0);
        check("reset_rd", 32'(bus.rd_data), 32'h0);
        rst_n = 1'b1;
        tick();

        // good frame
        send(8'hAA); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        check("good_not_yet", 32'(bus.pkt_ready), 32'd0);
        send(8'h03);
        check("good_ready", 32'(bus.pkt_ready), 32'd1);
        check("good_len", 32'(bus.pkt_len), 32'd3);
        bus.rd_addr = 4'd0; tick(); check("good_rd0", 32'(bus.rd_data), 32'h11);
        bus.rd_addr = 4'd1; tick(); check("good_rd1", 32'(bus.rd_data), 32'h22);
        bus.rd_addr = 4'd2; tick(); check("good_rd2", 32'(bus.rd_data), 32'h33);
        ack();
        check("good_released", 32'(bus.pkt_ready), 32'd0);
        ack();  // ignored outside HOLD
        tick();

        // bad checksum then a good frame
        send(8'hAA); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
        check("badchk_err", 32'(bus.pkt_err), 32'd1);
        tick();
        check("badchk_err_pulse", 32'(bus.pkt_err), 32'd0);
        check("badchk_ready", 32'(bus.pkt_ready), 32'd0);
        send(8'hAA); send(8'h01); send(8'h55); send(8'h54);
        check("after_bad_ready", 32'(bus.pkt_ready), 32'd1);
        ack();

        // bad lengths and leading noise
        send(8'hAA); send(8'h00);
        check("len0_err", 32'(bus.pkt_err), 32'd1);
        tick();
        send(8'hAA); send(8'h11);
        check("len17_err", 32'(bus.pkt_err), 32'd1);
        send(8'h00); send(8'hFF); send(8'h13);
        check("noise_no_err", 32'(bus.pkt_err), 32'd0);
        send(8'hAA); send(8'h01); send(8'h07); send(8'h06);
        check("noise_frame_ready", 32'(bus.pkt_ready), 32'd1);
        ack();

        // hold drops, ack together with a strobe
        send(8'hAA); send(8'h01); send(8'h5A); send(8'h5B);
        bus.rd_addr = 4'd0;
        for (int i = 0; i < 5; i++) send(8'hAA);
        check("drop5", 32'(bus.drop_cnt), 32'd5);
        check("drop5_rd", 32'(bus.rd_data), 32'h5A);
        bus.pkt_ack = 1'b1;
        send(8'hAA);
        bus.pkt_ack = 1'b0;
        check("ack_strobe_drop", 32'(bus.drop_cnt), 32'd6);
        check("ack_strobe_ready", 32'(bus.pkt_ready), 32'd0);
        tick();

        // hold overflow
        send(8'hAA); send(8'h01); send(8'hC3); send(8'hC2);
        for (int i = 0; i < 300; i++) send(8'(i));
        check("drop_sat", 32'(bus.drop_cnt), 32'hFF);
        check("hold_rd_stable", 32'(bus.rd_data), 32'hC3);
        check("hold_still_ready", 32'(bus.pkt_ready), 32'd1);
        ack();

        // maximum length with embedded SYNC bytes; CHK = 8'hBB
        send(8'hAA); send(8'h10);
        for (int i = 0; i < 16; i++) send(pay35[i]);
        send(8'hBB);
        check("max_ready", 32'(bus.pkt_ready), 32'd1);
        check("max_len", 32'(bus.pkt_len), 32'd16);
        for (int i = 0; i < 16; i++) begin
            bus.rd_addr = AW'(i);
            tick();
            check("max_rd", 32'(bus.rd_data), 32'(pay35[i]));
        end
        ack();

        // reset mid-frame
        send(8'hAA); send(8'h04); send(8'h01);
        rst_n = 1'b0;
        tick();
        check("midrst_ready", 32'(bus.pkt_ready), 32'd0);
        check("midrst_drop", 32'(bus.drop_cnt), 32'd0);
        check("midrst_len", 32'(bus.pkt_len), 32'd0);
        rst_n = 1'b1;
        tick();
        send(8'h02); send(8'h03);
        check("midrst_ignored", 32'(bus.pkt_ready), 32'd0);
        send(8'hAA); send(8'h02); send(8'h0F); send(8'hF0); send(8'hFD);
        check("midrst_new_frame", 32'(bus.pkt_ready), 32'd1);
        check("midrst_new_len", 32'(bus.pkt_len), 32'd2);
        ack();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
